// File: rtl/bus_mem_ctrl_if.sv
// Bus-side signal bundle between the snoopy bus and the main-memory controller.
// The master modport is the bus/arbiter side, the slave modport is the controller.
interface bus_mem_ctrl_if #(
  parameter int ADDR_SIZE       = 32,
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       bus_valid_i;
  logic [1:0]                 bus_msg_i;
  logic [ADDR_SIZE-1:0]       bus_addr_i;
  logic                       flush_i;
  logic [CACHE_LINE_SIZE-1:0] flush_data_i;
  logic                       mem_busy_o;
  logic                       data_valid_o;
  logic [CACHE_LINE_SIZE-1:0] data_o;
  logic [ADDR_SIZE-1:0]       resp_addr_o;
  logic                       overrun_o;

  modport master (
    output bus_valid_i, bus_msg_i, bus_addr_i, flush_i, flush_data_i,
    input  mem_busy_o, data_valid_o, data_o, resp_addr_o, overrun_o
  );

  modport slave (
    input  bus_valid_i, bus_msg_i, bus_addr_i, flush_i, flush_data_i,
    output mem_busy_o, data_valid_o, data_o, resp_addr_o, overrun_o
  );
endinterface

// File: rtl/bus_mem_ctrl.sv
// Main-memory controller on the MSI snoopy bus: answers BusRd/BusRdX after a
// fixed latency and absorbs owner flushes as write-backs.
// Handshake: a transaction is accepted on an edge where bus_valid_i=1 and
// mem_busy_o=0; any bus_valid_i while mem_busy_o=1 is dropped and sets overrun_o.
module bus_mem_ctrl #(
  parameter int             ADDR_SIZE       = 32,
  parameter int             CACHE_LINE_SIZE = 128,
  parameter int             MEM_WORDS       = 16,
  parameter int             MEM_LATENCY     = 4,
  parameter logic [CACHE_LINE_SIZE-1:0] INIT_WORD = {8{16'hCAFE}}
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bus_mem_ctrl_if.slave        bus_if,
  output logic [1:0]           state_dbg_o
);
  localparam int OFF_W = $clog2(CACHE_LINE_SIZE / 8);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [ADDR_SIZE-1:0]       addr_q, addr_d;
  logic [ADDR_SIZE-1:0]       resp_addr_q, resp_addr_d;
  logic                       overrun_q, overrun_d;
  logic [CACHE_LINE_SIZE-1:0] mem_q [MEM_WORDS];

  logic             accept;
  logic             is_read;
  logic             do_write;
  logic [IDX_W-1:0] bus_idx;

  assign bus_idx  = bus_if.bus_addr_i[OFF_W+IDX_W-1:OFF_W];
  assign accept   = bus_if.bus_valid_i && (state_q == S_IDLE);
  assign is_read  = (bus_if.bus_msg_i == 2'b00) || (bus_if.bus_msg_i == 2'b01);
  assign do_write = accept && bus_if.flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      resp_addr_q <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= INIT_WORD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      resp_addr_q <= resp_addr_d;
      overrun_q   <= overrun_d;
      if (do_write) mem_q[bus_idx] <= bus_if.flush_data_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    overrun_d = overrun_q || (bus_if.bus_valid_i && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        if (accept && !bus_if.flush_i && is_read) begin
          idx_d   = bus_idx;
          addr_d  = bus_if.bus_addr_i;
          cnt_d   = LAT_M1;
          state_d = (MEM_LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // resp_addr only moves when a response begins, so it holds between responses.
  always_comb begin
    resp_addr_d = resp_addr_q;
    if (state_d == S_RESP && state_q != S_RESP)
      resp_addr_d = (state_q == S_IDLE) ? bus_if.bus_addr_i : addr_q;
  end

  always_comb begin
    bus_if.mem_busy_o   = (state_q == S_WAIT) || (state_q == S_RESP);
    bus_if.data_valid_o = (state_q == S_RESP);
    bus_if.data_o       = (state_q == S_RESP) ? mem_q[idx_q] : '0;
    bus_if.resp_addr_o  = resp_addr_q;
    bus_if.overrun_o    = overrun_q;
    state_dbg_o         = state_q;
  end
endmodule

// File: doc/bus_mem_ctrl.md
Name: bus_mem_ctrl

Overview:
Main-memory controller for the MSI snoopy bus. It consumes the transaction the bus arbiter places on the shared lines each granted cycle. On BusRd and BusRdX it returns a full cache line after a fixed latency. When the owning cache drives a flush, it absorbs the flushed line as a write-back. It sits downstream of the bus, in parallel with the snooping caches, and is the only data source on a snoop miss.

Parameters:
ADDR_SIZE, 32, bus address width
CACHE_LINE_SIZE, 128, line width in bits; byte offset = log2(CACHE_LINE_SIZE/8) = 4
MEM_WORDS, 16, number of lines held; power of two; IDX_W = log2(MEM_WORDS)
MEM_LATENCY, 4, cycles from accept to data_valid_o; legal range 1..15
INIT_WORD, {8{16'hCAFE}}, reset contents of every line

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-low (0 = reset)
bus_valid_i  in  1  bus carries a granted transaction this cycle
bus_msg_i  in  2  00 BusRd, 01 BusRdX, 10 BusUpgr, 11 none
bus_addr_i  in  ADDR_SIZE  transaction address
flush_i  in  1  owner cache is flushing this line this cycle
flush_data_i  in  CACHE_LINE_SIZE  flushed line
mem_busy_o  out  1  controller cannot accept a transaction
data_valid_o  out  1  one-cycle strobe: data_o and resp_addr_o are valid
data_o  out  CACHE_LINE_SIZE  line returned for read
resp_addr_o  out  ADDR_SIZE  latched address of the transaction being answered
overrun_o  out  1  sticky error: a transaction arrived while busy

Behaviour:
- Index = bus_addr_i[4+IDX_W-1:4]. Upper bits are ignored (aliasing is allowed).
- Reset (rst_i=0 at an edge):
  - state=IDLE, all MEM_WORDS lines = INIT_WORD, latency counter=0.
  - mem_busy_o=0, data_valid_o=0, data_o=0, resp_addr_o=0, overrun_o=0.
  - Reset mid-transaction aborts it with no response.
- States: IDLE, WAIT, RESP.
- IDLE, accept when bus_valid_i=1:
  - flush_i=1, any msg: mem[index] <= flush_data_i at that edge. No read response, since the flushing cache supplies the requester. Stay in IDLE.
  - flush_i=0, msg 00 or 01: latch index and address, counter <= MEM_LATENCY-1. Go to WAIT, or directly to RESP when MEM_LATENCY=1.
  - flush_i=0, msg 10 or 11: no action, stay in IDLE.
- WAIT: counter decrements each cycle; at 1 go to RESP.
- RESP (one cycle): data_valid_o=1, data_o=mem[latched index], resp_addr_o=latched address. Next state IDLE.
- Timing: accept in cycle 0 gives data_valid_o high in cycle MEM_LATENCY. mem_busy_o=1 in cycles 1..MEM_LATENCY. A new transaction is acceptable in cycle MEM_LATENCY+1.
- Outside RESP: data_valid_o=0 and data_o=0. resp_addr_o holds its last value.
- mem_busy_o is combinational from state: 1 in WAIT or RESP.
- bus_valid_i=1 while mem_busy_o=1:
  - The transaction is dropped and memory is not written, flush included.
  - overrun_o <= 1 and stays 1 until reset.
  - The in-flight response is unaffected.
- bus_valid_i=0: flush_i and the data inputs are ignored.
- Read data is sampled from the array in the RESP cycle. Flushes only occur in IDLE, so there is no read/write collision.

Test Plan:
- Reset then BusRd addr 0x30 (index 3), cycle 0 → mem_busy_o=1 in cycles 1-4; data_valid_o=1 only in cycle 4 with data_o={8{16'hCAFE}}, resp_addr_o=0x30.
- Flush to addr 0x50 with data 128'h1234_..._ABCD, then BusRdX 0x50 next cycle → data_valid_o 4 cycles later with data_o=128'h1234_..._ABCD; mem_busy_o stays 0 during the flush cycle.
- BusUpgr addr 0x10, and msg 11 with bus_valid_i=1 → no busy, no data_valid_o, memory unchanged (a later BusRd 0x10 returns CAFE pattern).
- BusRd 0x20 in cycle 0, then a flush to 0x20 with data all-ones in cycle 2 → overrun_o=1 from cycle 3 onward; cycle 4 data_o = CAFE pattern; later read of 0x20 still returns CAFE.
- Aliasing: flush 0x1_0070 (data 0xAA repeated), BusRd 0x70 → data_o = 0xAA repeated.
- rst_i=0 in cycle 2 of a BusRd → no data_valid_o at cycle 4, mem_busy_o=0 and overrun_o=0 after reset; previously flushed lines read back INIT_WORD. Repeat first case with MEM_LATENCY=1: data_valid_o in cycle 1.
